serial_borrow_subtractor: RTL and testbench

//   Bit-serial ripple-borrow subtractor: the inverse of the team's ripple-carry adder.

---
 rtl/serial_borrow_subtractor.sv | 105 ++++++++++
 tb/tb_serial_borrow_subtractor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = {borrow_out, (a - b) mod 2^WIDTH}, one bit per clock,
// LSB first, with a valid/ready handshake on both sides.
module serial_borrow_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   diff
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state,  w_state_next;
  logic [WIDTH-1:0] r_sa,     w_sa_next;
  logic [WIDTH-1:0] r_sb,     w_sb_next;
  logic [WIDTH-1:0] r_res,    w_res_next;
  logic             r_borrow, w_borrow_next;
  logic [CW-1:0]    r_count,  w_count_next;
  logic [WIDTH:0]   r_diff,   w_diff_next;

  logic             w_d;
  logic             w_borrow_calc;
  logic [WIDTH-1:0] w_res_shift;

  // Full-subtractor cell on the current LSB pair.
  assign w_d           = r_sa[0] ^ r_sb[0] ^ r_borrow;
  assign w_borrow_calc = (~r_sa[0] & r_sb[0]) | (~r_sa[0] & r_borrow) | (r_sb[0] & r_borrow);
  assign w_res_shift   = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_sa     <= '0;
      r_sb     <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
      r_diff   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_sa     <= w_sa_next;
      r_sb     <= w_sb_next;
      r_res    <= w_res_next;
      r_borrow <= w_borrow_next;
      r_count  <= w_count_next;
      r_diff   <= w_diff_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_sa_next     = r_sa;
    w_sb_next     = r_sb;
    w_res_next    = r_res;
    w_borrow_next = r_borrow;
    w_count_next  = r_count;
    w_diff_next   = r_diff;

    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_sa_next     = a;
          w_sb_next     = b;
          w_res_next    = '0;
          w_borrow_next = 1'b0;
          w_count_next  = '0;
          w_state_next  = StRun;
        end
      end
      StRun: begin
        w_sa_next     = r_sa >> 1;
        w_sb_next     = r_sb >> 1;
        w_res_next    = w_res_shift;
        w_borrow_next = w_borrow_calc;
        w_count_next  = r_count + CW'(1);
        // Last bit: publish result together with the final borrow.
        if (r_count == CW'(WIDTH - 1)) begin
          w_diff_next  = {w_borrow_calc, w_res_shift};
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign diff      = r_diff;

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Scoreboard bench for serial_borrow_subtractor: driver pushes expected diffs, monitor pops on
// each output handshake.
module tb_serial_borrow_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] diff;

  logic [4:0] exp_q[$];
  logic [4:0] mon_exp;
  int         n_tests;
  int         n_fail;
  int         cyc;
  int         last_acc;
  bit         chk_spacing;
  int         lat;

  serial_borrow_subtractor #(.WIDTH(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!in_ready) timeout_fail("wait_ready");
  endtask

  task automatic issue(input logic [3:0] ia, input logic [3:0] ib, input logic [4:0] exp);
    a = ia;
    b = ib;
    wait_ready();
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (exp_q.size() != 0) timeout_fail("drain");
  endtask

  // Cycle counter and accept tracker (accept happens at the edge after this negedge).
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      if (chk_spacing && last_acc >= 0) check("accept_spacing", cyc - last_acc, 6);
      last_acc = cyc;
    end
  end

  // Monitor: handshake completes at the following rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got %0d expected none", diff);
      end else begin
        mon_exp = exp_q.pop_front();
        check("diff", 32'(diff), 32'(mon_exp));
      end
    end
  end

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    cyc         = 0;
    last_acc    = -1;
    chk_spacing = 1'b0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    a           = '0;
    b           = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 1);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_diff", 32'(diff), 0);
    rst_n = 1'b1;

    // 7 - 3: latency and in_ready low through RUN.
    issue(4'd7, 4'd3, 5'b00100);
    lat = 1;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) break;
      check("run_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 5);
    drain();

    issue(4'd3, 4'd7, 5'b11100);
    issue(4'd0, 4'd15, 5'b10001);
    issue(4'd15, 4'd15, 5'b00000);
    issue(4'd0, 4'd0, 5'b00000);
    drain();

    // Back-pressure: result and state frozen while out_ready is low.
    out_ready = 1'b0;
    issue(4'd9, 4'd2, 5'b00111);
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 10; k++) begin
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_diff", 32'(diff), 7);
      check("bp_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", 32'(in_ready), 1);
    check("bp_release_out_valid", 32'(out_valid), 0);
    drain();

    // Reset on the 2nd RUN edge discards the operation.
    issue(4'd12, 4'd5, 5'b00111);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_diff", 32'(diff), 0);
    check("abort_in_ready", 32'(in_ready), 1);
    void'(exp_q.pop_back());
    rst_n = 1'b1;
    issue(4'd1, 4'd1, 5'b00000);
    drain();

    // Exhaustive sweep with in_valid held high.
    last_acc    = -1;
    chk_spacing = 1'b1;
    in_valid    = 1'b1;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        a = 4'(ai);
        b = 4'(bi);
        wait_ready();
        @(posedge clk);
        exp_q.push_back(5'((ai - bi) & 31));
        #1;
      end
    end
    in_valid = 1'b0;
    drain();
    chk_spacing = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
